// File: rtl/gm_pkg.sv
// gm_pkg
// Shared definitions for the GoldMiner on-chip RAM readers.
//   GM_ADDR_W / GM_DATA_W : default RAM word-address and data widths
//   MEM_WORDS             : RAM depth in words; transfer lengths clamp to it
//   gm_state_e            : stream-reader control states
package gm_pkg;

  localparam int GM_ADDR_W = 10;
  localparam int GM_DATA_W = 32;
  localparam int MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } gm_state_e;

endpackage

// File: rtl/gm_sync_fifo.sv
// gm_sync_fifo
// Small synchronous FIFO with first-word-fall-through output.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count)
//   flush        : empties the FIFO; overrides a same-cycle write or read
//   wr_en/wr_data: push one word
//   rd_en        : pop the head word (ignored when empty)
//   rd_data      : head word, forced to 0 while empty
//   empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module gm_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !flush;
  assign do_rd = rd_en && !flush && (count_reg != '0);

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/gm_mem_stream_reader.sv
// gm_mem_stream_reader
// Reads a contiguous, wrapping word range from RAM port 2 and streams it out.
//   start/base_addr/word_count : transfer command (sampled in IDLE only)
//   abort                      : cancel an active transfer, no done pulse
//   busy, done                 : status; done pulses one cycle on completion
//   mem_*                      : RAM port-2 read interface (1-cycle latency)
//   out_data/valid/ready/last  : output stream, FIFO head
module gm_mem_stream_reader
  import gm_pkg::*;
#(
  parameter int ADDR_W     = GM_ADDR_W,
  parameter int DATA_W     = GM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  gm_state_e         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  issue_left_reg;
  logic [CNT_W-1:0]  beat_left_reg;
  logic              inflight_reg;
  logic              done_reg;

  logic [CNT_W-1:0]  count_clamped;
  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W:0]   occupancy;
  logic              fifo_empty;
  logic              abort_eff;
  logic              issue;
  logic              handshake;

  assign count_clamped = (word_count > CNT_W'(MEM_WORDS)) ? CNT_W'(MEM_WORDS) : word_count;

  // abort only matters while a transfer is active
  assign abort_eff = abort && (state_reg != ST_IDLE);

  // Reserve a FIFO slot for the read still in flight so the capture never overflows.
  assign occupancy = {1'b0, fifo_count} + (FCNT_W + 1)'(inflight_reg);
  assign issue     = (state_reg == ST_READ) && !abort_eff && (issue_left_reg != '0)
                     && (occupancy < (FCNT_W + 1)'(FIFO_DEPTH));
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      issue_left_reg <= '0;
      beat_left_reg  <= '0;
      inflight_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (abort_eff) begin
        state_reg      <= ST_IDLE;
        issue_left_reg <= '0;
        beat_left_reg  <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (count_clamped == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg      <= ST_READ;
                addr_reg       <= base_addr;
                issue_left_reg <= count_clamped;
                beat_left_reg  <= count_clamped;
              end
            end
          end
          ST_READ: begin
            if (issue) begin
              addr_reg       <= addr_reg + ADDR_W'(1);
              issue_left_reg <= issue_left_reg - CNT_W'(1);
              if (issue_left_reg == CNT_W'(1)) state_reg <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
          end
          default: state_reg <= ST_IDLE;
        endcase
        // Beats only exist after the first capture, so this never collides with IDLE's loads.
        if (handshake) begin
          beat_left_reg <= beat_left_reg - CNT_W'(1);
          if (beat_left_reg == CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
      end
    end
  end

  gm_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort_eff),
    .wr_en   (inflight_reg),
    .wr_data (mem_readdata),
    .rd_en   (handshake),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy           = (state_reg != ST_IDLE);
  assign done           = done_reg;
  assign mem_address    = addr_reg;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign out_valid      = !fifo_empty;
  assign out_last       = out_valid && (beat_left_reg == CNT_W'(1));

endmodule

// File: tb/tb_gm_mem_stream_reader.sv
// tb_gm_mem_stream_reader
// Randomized transfers against a reference model: word i of a transfer from
// base B must equal ram[(B+i) mod 1024], with length min(count,1024).
module tb_gm_mem_stream_reader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_readdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  gm_mem_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  // RAM port-2 model: registered read, one cycle after the issue.
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) if (mem_chipselect) mem_readdata <= ram[mem_address];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  bit            mon_en = 0;
  int            m_base, m_n, s_cyc, iss_n, hs_n, first_valid, done_cyc, done_cnt;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            rdy_mode = 0;
  int            rdy_phase = 0;

  // consumer ready pattern, driven just after each rising edge
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1: begin out_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3); rdy_phase++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_write", 64'(mem_write), 64'(0));
      chk("fifo_occ_le4", 64'(dut.u_fifo.count_reg <= 3'd4), 64'(1));
      if (mem_chipselect) begin
        chk("iss_addr", 64'(mem_address), 64'((m_base + iss_n) % 1024));
        chk("iss_bound", 64'(iss_n < m_n), 64'(1));
        iss_n++;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && first_valid < 0) first_valid = cyc - s_cyc + 1;
      if (out_valid && out_ready) begin
        chk("beat_bound", 64'(hs_n < m_n), 64'(1));
        chk("data", 64'(out_data), 64'(ram[(m_base + hs_n) % 1024]));
        chk("last", 64'(out_last), 64'(hs_n == m_n - 1));
        hs_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - s_cyc + 1;
      end
    end
  end

  task automatic start_xfer(input int b, input int c, input int rm);
    m_base = b; m_n = (c > 1024) ? 1024 : c;
    iss_n = 0; hs_n = 0; first_valid = -1; done_cyc = -1; done_cnt = 0;
    prev_stall = 0; rdy_mode = rm; rdy_phase = 0;
    @(posedge clk); #2;
    start = 1'b1; base_addr = AW'(b); word_count = (AW + 1)'(c);
    s_cyc = cyc + 1; mon_en = 1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) break;
    end
    chk("done_seen", 64'(done_cnt > 0), 64'(1));
    chk("busy_at_done", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #2;
    mon_en = 0;
  endtask

  task automatic finish_checks(input bit timing);
    chk("beats", 64'(hs_n), 64'(m_n));
    chk("issues", 64'(iss_n), 64'(m_n));
    chk("done_once", 64'(done_cnt), 64'(1));
    if (timing) begin
      if (m_n > 0) begin
        chk("first_valid_cyc", 64'(first_valid), 64'(3));
        chk("done_cyc", 64'(done_cyc), 64'(m_n + 3));
      end else begin
        chk("done_cyc_zero", 64'(done_cyc), 64'(1));
        chk("no_valid_zero", 64'(first_valid), 64'(-1));
      end
    end
    $display("xfer base=%03h count=%0d beats=%0d done_cyc=%0d", m_base, m_n, hs_n, done_cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_cs"}, 64'(mem_chipselect), 64'(0));
    chk({tag, "_addr"}, 64'(mem_address), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_last"}, 64'(out_last), 64'(0));
    chk({tag, "_data"}, 64'(out_data), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    #3;
    chk_reset_outputs("rst");
    chk("byteenable", 64'(mem_byteenable), 64'(4'hF));
    chk("clken", 64'(mem_clken), 64'(1));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    start_xfer(32'h010, 8, 0);   wait_done(100);  finish_checks(1);
    start_xfer(32'h3FE, 4, 0);   wait_done(100);  finish_checks(1);
    start_xfer(32'h123, 6, 1);   wait_done(200);  finish_checks(0);
    start_xfer(32'h005, 0, 0);   wait_done(20);   finish_checks(1);
    start_xfer(32'h200, 2000, 2); wait_done(5000); finish_checks(0);

    // abort after the 5th handshake
    start_xfer(32'h040, 16, 0);
    for (int k = 0; k < 200; k++) begin
      if (hs_n >= 5) break;
      @(posedge clk); #2;
    end
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_last", 64'(out_last), 64'(0));
    chk("abort_beats", 64'(hs_n == 5 || hs_n == 6), 64'(1));
    repeat (4) @(posedge clk);
    #2;
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_idle_valid", 64'(out_valid), 64'(0));
    mon_en = 0;
    $display("xfer base=040 count=16 aborted beats=%0d", hs_n);
    start_xfer(32'h100, 2, 0);   wait_done(100);  finish_checks(1);

    // asynchronous reset mid-transfer
    start_xfer(32'h2F0, 20, 0);
    repeat (8) @(posedge clk);
    #2;
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #2;
    chk_reset_outputs("midrst_hold");
    reset_n = 1'b1;
    $display("xfer base=2f0 count=20 reset after beats=%0d", hs_n);
    start_xfer(32'h2F0, 20, 0);  wait_done(200);  finish_checks(1);

    for (int r = 0; r < 6; r++) begin
      start_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)), 2);
      wait_done(500);
      finish_checks(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
